// File: rtl/retro_catc_pkg.sv
// retro_catc_pkg
// Shared definitions for the CATC audio path: the output-buffer state
// encoding and the default clock / sample-rate constants used as parameter
// defaults by catc_audio_buffer and other CATC consumers.
package retro_catc_pkg;

  localparam int unsigned DefaultCoreClock  = 200000000;
  localparam int unsigned DefaultSampleRate = 44100;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/catc_rate_divider.sv
// catc_rate_divider
// Generates a one-cycle Tick every Div enabled clock cycles.
// Ports:
//   Clk   - core clock
//   Reset - synchronous active-high reset, clears the counter
//   ClkEn - count enable; the counter holds when low
//   Tick  - high on the enabled cycle where the counter sits at Div-1
module catc_rate_divider #(
  parameter int unsigned Div = 10
) (
  input  logic Clk,
  input  logic Reset,
  input  logic ClkEn,
  output logic Tick
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] LastCount = CntW'(Div - 1);

  logic [CntW-1:0] count_q, count_d;

  // Tick is combinational so the consumer acts on the same cycle the
  // counter reaches its last value, then the counter wraps to zero.
  assign Tick = ClkEn && (count_q == LastCount);

  always_comb begin
    count_d = count_q;
    if (ClkEn) begin
      count_d = (count_q == LastCount) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/catc_audio_buffer.sv
// catc_audio_buffer
// Smooths bursty samples from the core into a steady-rate output stream.
// Samples are queued in a small FIFO; a rate divider pops one per output
// tick. After reset or an underflow the buffer primes until half full.
// Ports:
//   Clk, Reset    - core clock, synchronous active-high reset
//   ClkEn         - global enable; all state holds when low
//   SampleValid/SampleIn - incoming sample (jittered timing)
//   SampleOut     - registered steady-rate sample
//   SampleStrobe  - pulses when SampleOut updates (every tick)
//   Level         - current FIFO occupancy
//   Underflow     - pulses on a RUN tick with the FIFO empty
//   Overflow      - pulses when an incoming sample is dropped
module catc_audio_buffer
  import retro_catc_pkg::*;
#(
  parameter int unsigned CoreClock  = DefaultCoreClock,
  parameter int unsigned SampleRate = DefaultSampleRate,
  parameter int unsigned Depth      = 16,
  parameter int unsigned Width      = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     ClkEn,
  input  logic                     SampleValid,
  input  logic [Width-1:0]         SampleIn,
  output logic [Width-1:0]         SampleOut,
  output logic                     SampleStrobe,
  output logic [$clog2(Depth):0]   Level,
  output logic                     Underflow,
  output logic                     Overflow
);

  localparam int unsigned Div = CoreClock / SampleRate;
  localparam int unsigned AW  = $clog2(Depth);
  localparam int unsigned LW  = AW + 1;
  localparam logic [LW-1:0] DepthLevel = LW'(Depth);
  localparam logic [LW-1:0] HalfLevel  = LW'(Depth / 2);

  logic             tick;
  logic             readEn, writeEn;
  state_e           state_q, state_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [Width-1:0] sampleOut_q, sampleOut_d;
  logic             strobe_q, strobe_d;
  logic             under_q, under_d;
  logic             over_q, over_d;
  logic [Width-1:0] mem [Depth];

  catc_rate_divider #(
    .Div (Div)
  ) u_divider (
    .Clk   (Clk),
    .Reset (Reset),
    .ClkEn (ClkEn),
    .Tick  (tick)
  );

  // Tick handling and write acceptance. All decisions use the pre-write
  // level, so a sample arriving on a tick can never be popped that same
  // cycle, but a pop frees the slot a write into a full FIFO needs.
  always_comb begin
    state_d     = state_q;
    rdPtr_d     = rdPtr_q;
    wrPtr_d     = wrPtr_q;
    level_d     = level_q;
    sampleOut_d = sampleOut_q;
    strobe_d    = 1'b0;
    under_d     = 1'b0;
    over_d      = 1'b0;
    readEn      = 1'b0;
    writeEn     = 1'b0;

    if (ClkEn) begin
      if (tick) begin
        strobe_d = 1'b1;
        if (state_q == PRIME) begin
          if (level_q >= HalfLevel) begin
            readEn  = 1'b1;
            state_d = RUN;
          end
        end else if (level_q == '0) begin
          under_d = 1'b1;
          state_d = PRIME;
        end else begin
          readEn = 1'b1;
        end
      end

      if (SampleValid) begin
        if ((level_q < DepthLevel) || readEn) begin
          writeEn = 1'b1;
        end else begin
          over_d = 1'b1;
        end
      end
    end

    if (readEn) begin
      sampleOut_d = mem[rdPtr_q];
      rdPtr_d     = rdPtr_q + 1'b1;
    end
    if (writeEn) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end

    case ({writeEn, readEn})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= PRIME;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      level_q     <= '0;
      sampleOut_q <= '0;
      strobe_q    <= 1'b0;
      under_q     <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      level_q     <= level_d;
      sampleOut_q <= sampleOut_d;
      strobe_q    <= strobe_d;
      under_q     <= under_d;
      over_q      <= over_d;
    end
  end

  // Storage is not cleared on reset; zeroing the level and pointers is
  // enough to make old contents unreachable.
  always_ff @(posedge Clk) begin
    if (!Reset && writeEn) begin
      mem[wrPtr_q] <= SampleIn;
    end
  end

  assign SampleOut    = sampleOut_q;
  assign SampleStrobe = strobe_q;
  assign Level        = level_q;
  assign Underflow    = under_q;
  assign Overflow     = over_q;

endmodule

// File: tb/tb_catc_audio_buffer.sv
// tb_catc_audio_buffer
// Self-checking bench for catc_audio_buffer with Div=10, Depth=4, Width=16.
// A queue-based reference model tracks the expected outputs every cycle,
// a stimulus table covers the overflow burst, and hand-written sequences
// cover priming, underflow, full-FIFO writes, enable gating and reset.
module tb_catc_audio_buffer;

  localparam int unsigned CoreClockT  = 1000;
  localparam int unsigned SampleRateT = 100;
  localparam int          DivT        = 10;
  localparam int          DepthT      = 4;
  localparam int          WidthT      = 16;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              ClkEn;
  logic              SampleValid;
  logic [WidthT-1:0] SampleIn;
  logic [WidthT-1:0] SampleOut;
  logic              SampleStrobe;
  logic [2:0]        Level;
  logic              Underflow;
  logic              Overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state: enabled-cycle count, running flag, sample queue
  int                mCount;
  bit                mRun;
  logic [WidthT-1:0] mQ[$];
  logic [WidthT-1:0] mOut;
  bit                mStrobe, mUnder, mOver;

  typedef struct {
    logic              valid;
    logic [WidthT-1:0] data;
    logic [2:0]        expLevel;
    logic              expOver;
  } vec_t;

  vec_t burst[6];

  catc_audio_buffer #(
    .CoreClock  (CoreClockT),
    .SampleRate (SampleRateT),
    .Depth      (DepthT),
    .Width      (WidthT)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .ClkEn        (ClkEn),
    .SampleValid  (SampleValid),
    .SampleIn     (SampleIn),
    .SampleOut    (SampleOut),
    .SampleStrobe (SampleStrobe),
    .Level        (Level),
    .Underflow    (Underflow),
    .Overflow     (Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of the behavioural model, applied at the active edge.
  task automatic modelStep(input bit rst, input bit en, input bit valid, input logic [WidthT-1:0] data);
    bit tick;
    bit pop;
    int lvl;
    mStrobe = 1'b0;
    mUnder  = 1'b0;
    mOver   = 1'b0;
    if (rst) begin
      mCount = 0;
      mRun   = 1'b0;
      mQ.delete();
      mOut   = '0;
      return;
    end
    if (!en) return;
    tick   = (mCount == DivT - 1);
    mCount = tick ? 0 : mCount + 1;
    lvl    = mQ.size();
    pop    = 1'b0;
    if (tick) begin
      mStrobe = 1'b1;
      if (!mRun) begin
        if (lvl >= DepthT / 2) begin
          mRun = 1'b1;
          pop  = 1'b1;
        end
      end else if (lvl == 0) begin
        mUnder = 1'b1;
        mRun   = 1'b0;
      end else begin
        pop = 1'b1;
      end
    end
    if (pop) mOut = mQ.pop_front();
    if (valid) begin
      if (lvl < DepthT || pop) mQ.push_back(data);
      else mOver = 1'b1;
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".out"},    32'(SampleOut),    32'(mOut));
    checkValue({tag, ".strobe"}, 32'(SampleStrobe), 32'(mStrobe));
    checkValue({tag, ".level"},  32'(Level),        32'(mQ.size()));
    checkValue({tag, ".under"},  32'(Underflow),    32'(mUnder));
    checkValue({tag, ".over"},   32'(Overflow),     32'(mOver));
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input bit valid,
                               input logic [WidthT-1:0] data, input string tag);
    Reset       = rst;
    ClkEn       = en;
    SampleValid = valid;
    SampleIn    = data;
    @(posedge Clk);
    modelStep(rst, en, valid, data);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int strobes;
    int unders;
    int overs;
    logic [WidthT-1:0] outs[$];

    burst[0] = '{1'b1, 16'h0010, 3'd1, 1'b0};
    burst[1] = '{1'b1, 16'h0011, 3'd2, 1'b0};
    burst[2] = '{1'b1, 16'h0012, 3'd3, 1'b0};
    burst[3] = '{1'b1, 16'h0013, 3'd4, 1'b0};
    burst[4] = '{1'b1, 16'h0014, 3'd4, 1'b1};
    burst[5] = '{1'b1, 16'h0015, 3'd4, 1'b1};

    // Reset state
    applyStimulus(1, 1, 0, '0, "rst");
    applyStimulus(1, 1, 0, '0, "rst");
    checkValue("rst.out",    32'(SampleOut),    32'h0);
    checkValue("rst.level",  32'(Level),        32'h0);
    checkValue("rst.strobe", 32'(SampleStrobe), 32'h0);
    checkValue("rst.under",  32'(Underflow),    32'h0);
    checkValue("rst.over",   32'(Overflow),     32'h0);

    // Idle priming: strobes every tenth cycle, output stays zero
    strobes = 0;
    unders  = 0;
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(0, 1, 0, '0, "s1");
      if (SampleStrobe) strobes++;
      if (Underflow) unders++;
      if (i % 10 == 0) checkValue("s1.strobeAt", 32'(SampleStrobe), 32'h1);
    end
    checkValue("s1.strobes", 32'(strobes), 32'd3);
    checkValue("s1.unders",  32'(unders),  32'd0);
    checkValue("s1.out",     32'(SampleOut), 32'h0);

    // Two samples, first tick enters RUN, then drain and underflow
    applyStimulus(1, 1, 0, '0, "s2rst");
    unders = 0;
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(0, 1, (i <= 2), 16'(i), "s2");
      if (i > 20 && Underflow) unders++;
      if (i == 10) begin
        checkValue("s2.firstOut", 32'(SampleOut), 32'h0001);
        checkValue("s2.firstLvl", 32'(Level),     32'd1);
      end
      if (i == 20) begin
        checkValue("s2.secondOut", 32'(SampleOut), 32'h0002);
        checkValue("s2.secondLvl", 32'(Level),     32'd0);
      end
      if (i == 30) begin
        checkValue("s3.under", 32'(Underflow), 32'h1);
        checkValue("s3.out",   32'(SampleOut), 32'h0002);
      end
    end
    checkValue("s3.underOnce", 32'(unders), 32'd1);

    // Back-to-back burst overfills the FIFO, then drains in order
    applyStimulus(1, 1, 0, '0, "s4rst");
    overs = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, burst[i].valid, burst[i].data, "s4");
      checkValue("s4.tblLevel", 32'(Level),    32'(burst[i].expLevel));
      checkValue("s4.tblOver",  32'(Overflow), 32'(burst[i].expOver));
      if (Overflow) overs++;
    end
    checkValue("s4.overs", 32'(overs), 32'd2);
    outs.delete();
    for (int i = 7; i <= 40; i++) begin
      applyStimulus(0, 1, 0, '0, "s4drain");
      if (SampleStrobe && !Underflow) outs.push_back(SampleOut);
    end
    checkValue("s4.drainCount", 32'(outs.size()), 32'd4);
    for (int k = 0; k < 4 && k < outs.size(); k++) begin
      checkValue("s4.drainVal", 32'(outs[k]), 32'h10 + 32'(k));
    end

    // Write into a full FIFO on a RUN tick is accepted
    applyStimulus(1, 1, 0, '0, "s5rst");
    for (int i = 1; i <= 20; i++) begin
      if (i <= 4)       applyStimulus(0, 1, 1, 16'h001F + 16'(i), "s5");
      else if (i == 11) applyStimulus(0, 1, 1, 16'h0024, "s5");
      else if (i == 20) applyStimulus(0, 1, 1, 16'h0025, "s5");
      else              applyStimulus(0, 1, 0, '0, "s5");
      if (i == 11) checkValue("s5.fullBefore", 32'(Level), 32'd4);
    end
    checkValue("s5.over",  32'(Overflow),  32'h0);
    checkValue("s5.level", 32'(Level),     32'd4);
    checkValue("s5.out",   32'(SampleOut), 32'h0021);

    // Enable gating: no strobes, nothing moves, tick phase resumes
    for (int i = 21; i <= 25; i++) applyStimulus(0, 1, 0, '0, "s6");
    strobes = 0;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(0, 0, 1, 16'hBEEF, "s6hold");
      if (SampleStrobe) strobes++;
    end
    checkValue("s6.holdStrobes", 32'(strobes),   32'd0);
    checkValue("s6.holdLevel",   32'(Level),     32'd4);
    checkValue("s6.holdOut",     32'(SampleOut), 32'h0021);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 1, 0, '0, "s6resume");
      checkValue("s6.resumeStrobe", 32'(SampleStrobe), (i == 5) ? 32'h1 : 32'h0);
    end
    checkValue("s6.resumeOut", 32'(SampleOut), 32'h0022);
    applyStimulus(0, 1, 0, '0, "s6");
    applyStimulus(1, 0, 1, 16'h7777, "s6rst");
    checkValue("s6.rstLevel", 32'(Level),     32'd0);
    checkValue("s6.rstOut",   32'(SampleOut), 32'h0);

    // Randomized traffic against the model, alternating sparse and heavy
    applyStimulus(1, 1, 0, '0, "rndrst");
    for (int i = 0; i < 4000; i++) begin
      bit rst;
      bit en;
      bit valid;
      rst   = ($urandom_range(0, 599) == 0);
      en    = ($urandom_range(0, 9) != 0);
      valid = ((i / 500) % 2 == 1) ? ($urandom_range(0, 99) < 60)
                                   : ($urandom_range(0, 99) < 8);
      applyStimulus(rst, en, valid, 16'($urandom), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/catc_audio_buffer.md
CATC_AUDIO_BUFFER -- requirements
Module: catc_audio_buffer

Interface
REQ-001 The block SHALL have parameter CoreClock, default 200000000, FPGA core clock in Hz.
REQ-002 The block SHALL have parameter SampleRate, default 44100, output sample rate in Hz.
REQ-003 The block SHALL have parameter Depth, default 16, FIFO entries; power of two, at least 4.
REQ-004 The block SHALL have parameter Width, default 16, sample width in bits.
REQ-005 The block SHALL have port Clk  input  1  core clock; single clock domain.
REQ-006 The block SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-007 The block SHALL have port ClkEn  input  1  global enable; all state holds when low.
REQ-008 The block SHALL have port SampleValid  input  1  core presents a sample this cycle.
REQ-009 The block SHALL have port SampleIn  input  Width  sample from core (catch-up-jittered timing).
REQ-010 The block SHALL have port SampleOut  output  Width  steady-rate output sample, registered.
REQ-011 The block SHALL have port SampleStrobe  output  1  one-cycle pulse when SampleOut updates.
REQ-012 The block SHALL have port Level  output  $clog2(Depth)+1  current occupancy.
REQ-013 The block SHALL have port Underflow  output  1  one-cycle pulse on an output tick with FIFO empty in RUN.
REQ-014 The block SHALL have port Overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-015 Rate divider: Div = CoreClock / SampleRate (integer); counter counts 0..Div-1 on ClkEn cycles; Tick is true when counter == Div-1, then wraps to 0.
REQ-016 Write: on ClkEn && SampleValid, the sample is accepted if Level < Depth, or if Level == Depth and a read occurs the same cycle.
REQ-017 Otherwise the write is dropped and Overflow pulses the next cycle; FIFO contents are unchanged.
REQ-018 States: PRIME, RUN.
REQ-019 PRIME: no reads; on each Tick, SampleStrobe pulses and SampleOut repeats its last value.
REQ-020 PRIME -> RUN on the Tick where Level >= Depth/2, evaluated before that cycle's write; that Tick performs the first read.
REQ-021 RUN: on each Tick with Level > 0, the oldest entry is popped into SampleOut and SampleStrobe pulses the next cycle.
REQ-022 RUN, Tick with Level == 0: SampleOut holds, SampleStrobe and Underflow both pulse, and the state returns to PRIME.
REQ-023 Emptiness is judged on pre-write Level: there is no same-cycle write-to-read bypass.
REQ-024 Simultaneous accepted write and read leaves Level unchanged; read and write pointers each wrap modulo Depth.
REQ-025 Latency: SampleOut, SampleStrobe, Underflow and Overflow are registered one cycle after the causing Tick or write.
REQ-026 With ClkEn low, the divider, pointers, state and outputs hold, and pulse outputs are 0.

Reset
REQ-027 On Reset: state PRIME; divider 0; pointers 0; Level 0; SampleOut 0; SampleStrobe, Underflow and Overflow 0.
REQ-028 Reset asserted mid-operation discards all FIFO contents regardless of ClkEn, and takes priority over any write or Tick that cycle.

Structure
REQ-029 Package retro_catc_pkg SHALL hold the state enum (PRIME, RUN) and the default CoreClock and SampleRate constants.
REQ-030 The rate divider SHALL be a sub-module, catc_rate_divider (parameter Div; ports Clk, Reset, ClkEn, Tick), reusable by other CATC consumers.
REQ-031 FIFO storage SHALL be an inferred register array within catc_audio_buffer; no vendor primitives.

Verification (CoreClock=1000, SampleRate=100 -> Div=10; Depth=4; Width=16)
REQ-032 Scenario 1: Reset, then no writes for 30 cycles -> SampleStrobe at cycles 10, 20, 30; SampleOut=0; Underflow never pulses; state stays PRIME.
REQ-033 Scenario 2: write 0x0001 and 0x0002 before the first Tick -> first Tick enters RUN, SampleOut=0x0001; next Tick SampleOut=0x0002, Level=0.
REQ-034 Scenario 3: from Scenario 2, the third Tick with no further writes -> Underflow pulses once, SampleOut stays 0x0002, state PRIME.
REQ-035 Scenario 4: write 6 samples 0x10..0x15 back-to-back with no Tick -> Level=4; Overflow pulses twice; a subsequent drain outputs 0x10..0x13.
REQ-036 Scenario 5: Level=4 with a write on a RUN Tick cycle -> write accepted, no Overflow, Level stays 4.
REQ-037 Scenario 6: hold ClkEn low for 25 cycles mid-run -> no strobes and no state change; Tick timing resumes exactly where it paused; assert Reset mid-drain -> Level=0, SampleOut=0 next cycle.
